// File: rtl/msrv32_integer_file.sv
// msrv32 architectural integer register file: 32 x XLEN, x0 hardwired to zero, two combinational read ports.
// Define MSRV32_RF_BYPASS_EN to forward same-cycle write data onto a matching read port.
module msrv32_integer_file #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            ms_riscv32_mp_clk_in,
    input  logic            ms_riscv32_mp_rst_n_in,
    input  logic [AW-1:0]   rs_1_addr_in,
    input  logic [AW-1:0]   rs_2_addr_in,
    input  logic [AW-1:0]   rd_addr_in,
    input  logic            wr_en_in,
    input  logic [XLEN-1:0] rd_in,
    output logic [XLEN-1:0] rs_1_out,
    output logic [XLEN-1:0] rs_2_out
);

    logic [XLEN-1:0] regs [NREGS];
    logic            rst_ok;
    logic            wr_hit;

    // rst_ok rises on the first edge that samples reset high, so a write
    // coinciding with reset release is dropped rather than racing the clear.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in)
            rst_ok <= 1'b0;
        else
            rst_ok <= 1'b1;
    end

    assign wr_hit = wr_en_in && rst_ok && (rd_addr_in != '0);

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (wr_hit) begin
            regs[rd_addr_in] <= rd_in;
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
        logic [XLEN-1:0] val;
        val = regs[addr];
`ifdef MSRV32_RF_BYPASS_EN
        if (wr_hit && (addr == rd_addr_in))
            val = rd_in;
`endif
        if (addr == '0)
            val = '0;
        return val;
    endfunction

    always_comb begin
        rs_1_out = read_port(rs_1_addr_in);
        rs_2_out = read_port(rs_2_addr_in);
    end

endmodule

// File: tb/tb_msrv32_integer_file.sv
// Directed self-checking bench for msrv32_integer_file; expectations follow MSRV32_RF_BYPASS_EN when defined.
module tb_msrv32_integer_file;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rs_1_addr = '0;
    logic [4:0]  rs_2_addr = '0;
    logic [4:0]  rd_addr = '0;
    logic        wr_en = 1'b0;
    logic [31:0] rd_data = '0;
    logic [31:0] rs_1;
    logic [31:0] rs_2;

    int n_checks = 0;
    int n_fail   = 0;

    msrv32_integer_file dut (
        .ms_riscv32_mp_clk_in   (clk),
        .ms_riscv32_mp_rst_n_in (rst_n),
        .rs_1_addr_in           (rs_1_addr),
        .rs_2_addr_in           (rs_2_addr),
        .rd_addr_in             (rd_addr),
        .wr_en_in               (wr_en),
        .rd_in                  (rd_data),
        .rs_1_out               (rs_1),
        .rs_2_out               (rs_2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] hz_same;
        logic [31:0] e1, e2;

        // reset held: every address reads 0
        #2;
        rs_1_addr = 5'd5; rs_2_addr = 5'd31; #1;
        chk("reset_rs1", rs_1, 32'h0);
        chk("reset_rs2", rs_2, 32'h0);

        tick(); tick();
        rst_n = 1'b1;
        tick();                                  // first edge sampling reset high
        wr_en = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEAD_BEEF;
        tick();
        wr_en = 1'b0; rs_1_addr = 5'd5; #1;
        chk("x5_written", rs_1, 32'hDEAD_BEEF);

        // asynchronous reset mid-cycle
        #2; rst_n = 1'b0; #1;
        chk("async_clear_rs1", rs_1, 32'h0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("x5_after_release", rs_1, 32'h0);

        // basic write, both ports same address
        wr_en = 1'b1; rd_addr = 5'd7; rd_data = 32'h1234_5678;
        rs_1_addr = 5'd7; rs_2_addr = 5'd7;
        tick();
        wr_en = 1'b0; #1;
        chk("x7_rs1", rs_1, 32'h1234_5678);
        chk("x7_rs2", rs_2, 32'h1234_5678);
        rs_1_addr = 5'd6; rs_2_addr = 5'd8; #1;
        chk("x6_untouched", rs_1, 32'h0);
        chk("x8_untouched", rs_2, 32'h0);

        // x0 protection, same cycle and next cycle
        wr_en = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFF_FFFF;
        rs_1_addr = 5'd0; rs_2_addr = 5'd0; #1;
        chk("x0_same_cycle", rs_1, 32'h0);
        tick();
        wr_en = 1'b0; #1;
        chk("x0_next_rs1", rs_1, 32'h0);
        chk("x0_next_rs2", rs_2, 32'h0);

        // write disabled
        rd_addr = 5'd3; rd_data = 32'hAAAA_5555; rs_1_addr = 5'd3;
        tick();
        chk("x3_wr_dis", rs_1, 32'h0);

        // unknown destination with write disabled
        rd_addr = 'x; rd_data = 32'h5A5A_5A5A; rs_1_addr = 5'd7;
        tick();
        chk("x7_after_x_addr", rs_1, 32'h1234_5678);

        // same-cycle read/write hazard on x9
        wr_en = 1'b1; rd_addr = 5'd9; rd_data = 32'h1;
        tick();
        rd_data = 32'h2; rs_1_addr = 5'd9; rs_2_addr = 5'd9; #1;
`ifdef MSRV32_RF_BYPASS_EN
        hz_same = 32'h2;
`else
        hz_same = 32'h1;
`endif
        chk("hazard_rs2_same", rs_2, hz_same);
        chk("hazard_rs1_same", rs_1, hz_same);
        tick();
        wr_en = 1'b0; #1;
        chk("hazard_rs2_next", rs_2, 32'h2);

        // full sweep x1..x31
        wr_en = 1'b1;
        for (int i = 1; i < 32; i++) begin
            rd_addr = 5'(i);
            rd_data = i * 32'h0101_0101;
            tick();
        end
        wr_en = 1'b0; rd_addr = '0; rd_data = '0;
        for (int i = 0; i < 32; i++) begin
            rs_1_addr = 5'(i);
            rs_2_addr = 5'(32 - i);
            #1;
            e1 = (i == 0) ? 32'h0 : i * 32'h0101_0101;
            e2 = (i == 0) ? 32'h0 : (32 - i) * 32'h0101_0101;
            chk($sformatf("sweep_rs1_x%0d", i), rs_1, e1);
            chk($sformatf("sweep_rs2_x%0d", (32 - i) % 32), rs_2, e2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/msrv32_integer_file.md
Name: msrv32_integer_file

Overview:
- Architectural integer register file for the msrv32 core.
- It is the receiving end of the write-back path: it consumes the write-back mux result, the destination register index and the write enable from the write-back stage.
- It supplies the two source operands, rs1 and rs2, to the decode/execute stage.
- Storage is 32 x 32-bit with x0 hardwired to zero; optional write-to-read bypass.

Parameters:
- XLEN, 32, data width of each register and of the read/write data ports.
- NREGS, 32, number of architectural registers (x0..x31).
- AW, 5, register address width; must satisfy 2**AW == NREGS.

Ports:
- ms_riscv32_mp_clk_in  input  1  core clock; all state updates on rising edge.
- ms_riscv32_mp_rst_n_in  input  1  asynchronous, active-low reset.
- rs_1_addr_in  input  AW  source register 1 index.
- rs_2_addr_in  input  AW  source register 2 index.
- rd_addr_in  input  AW  destination register index from the write-back stage.
- wr_en_in  input  1  write enable from the write-back stage (register-write qualified).
- rd_in  input  XLEN  write data; this is the write-back mux output.
- rs_1_out  output  XLEN  operand read for rs_1_addr_in.
- rs_2_out  output  XLEN  operand read for rs_2_addr_in.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset:
  - On ms_riscv32_mp_rst_n_in low, all registers x0..x31 clear to 32'h0000_0000 immediately, without waiting for a clock edge.
  - While reset is held, rs_1_out and rs_2_out read 0 for every address.
  - A write presented in a cycle where reset is low, or where reset deasserts, is discarded.
  - The first write accepted is on the first rising edge after reset is sampled high.
- Write port:
  - On a rising edge with wr_en_in=1 and rd_addr_in!=0, register[rd_addr_in] <= rd_in.
  - Write latency is 1 cycle: the stored value is visible to the array read path from the next cycle.
  - wr_en_in=0 leaves every register unchanged, whatever rd_addr_in and rd_in are.
- x0:
  - Writes with rd_addr_in==0 are ignored.
  - Reads of address 0 return 0 unconditionally on both ports, including when bypass is enabled.
- Read ports:
  - Both read ports are purely combinational from the address and the array (zero latency).
  - The two ports are fully independent; rs_1_addr_in==rs_2_addr_in returns the same value on both.
- Simultaneous read and write of the same nonzero register:
  - Without bypass, the read returns the old value in that cycle and the new value from the next cycle.
  - With bypass, see Optional Feature.
- Width rules:
  - rd_in is stored unmodified, with no sign or zero handling.
  - Addresses are not range-checked; the full AW range maps 1:1 onto NREGS.
- X-handling: unknown rd_addr_in while wr_en_in=0 must not corrupt state.

Optional Feature:
- Macro: MSRV32_RF_BYPASS_EN.
- Defined: each read port compares its address with rd_addr_in. The port outputs rd_in in the same cycle when all of the following hold:
  - wr_en_in=1;
  - rd_addr_in!=0;
  - the addresses match;
  - reset is deasserted.
  - Otherwise the port outputs the array value.
  - This removes the write-back-to-decode hazard bubble.
- Not defined: no comparator logic is instantiated; reads always return array contents and same-cycle writes are visible one cycle later.
- Both builds must be functionally identical whenever there is no same-cycle read/write address match.

Test Plan:
- Reset then read: assert rst_n low mid-run after writing x5=32'hDEAD_BEEF, then read x5 on rs_1 -> 0 immediately (asynchronously); after release, rs_1 still 0 until rewritten.
- Basic write/read: wr_en=1, rd_addr=7, rd_in=32'h1234_5678 at edge N -> rs_1 (addr 7) and rs_2 (addr 7) both read 32'h1234_5678 from cycle N+1; other registers stay 0.
- x0 protection: wr_en=1, rd_addr=0, rd_in=32'hFFFF_FFFF -> rs_1 addr 0 reads 0 in the same cycle and the next cycle, in both builds.
- Write disabled: wr_en=0, rd_addr=3, rd_in=32'hAAAA_5555 -> x3 remains at its prior value (0 after reset).
- Same-cycle hazard: x9=32'h1 stored; in one cycle wr_en=1, rd_addr=9, rd_in=32'h2 with rs_2_addr=9:
  - without MSRV32_RF_BYPASS_EN, rs_2 reads 32'h1 in that cycle and 32'h2 the next cycle;
  - with MSRV32_RF_BYPASS_EN, rs_2 reads 32'h2 in the same cycle.
- Full sweep: write x1..x31 with value (index*32'h0101_0101) on consecutive cycles, then read pairs (i, 32-i) -> every read matches its pattern, x0 reads 0, and there is no aliasing.
